// File: rtl/apb_arb_pkg.sv
// Shared types for the APB master arbiter: FSM state encoding, requester limit,
// and fallback bus widths for builds that do not define ADDR_WIDTH/DATA_WIDTH.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package apb_arb_pkg;
  localparam int ARB_MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_arb_state_e;
endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin pick: first active request at or after the pointer.
// Latency: grant is combinational; pointer moves to grant+1 on the next edge.
// Backpressure: none; the parent only presents requests when it can accept a grant.
module apb_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic               pclk,
  input  logic               presetn,
  input  logic [NUM_REQ-1:0] req,
  output logic               gnt_vld,
  output logic [IDX_W-1:0]   gnt_idx
);
  logic [IDX_W-1:0] ptr;
  int               idx;

  // Walk from the farthest slot back to the pointer so the nearest match wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDX_W'(idx);
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      ptr <= '0;
    end else if (gnt_vld) begin
      ptr <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end
endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master among NUM_REQ requesters (optional ACCESS timeout: APB_ARB_TIMEOUT_EN).
// Latency: 3 cycles request-to-done minimum; back-to-back transfers 2 cycles plus waits.
// Backpressure: requesters hold until req_done; pready stalls ACCESS.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int TIMEOUT    = 16
) (
  input  logic                          pclk,
  input  logic                          presetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_done,
  output logic [DATA_WIDTH-1:0]         req_rdata,
  output logic                          req_slverr,
  output logic                          busy,
  output logic                          psel,
  output logic                          penable,
  output logic                          pwrite,
  output logic [ADDR_WIDTH-1:0]         paddr,
  output logic [DATA_WIDTH-1:0]         pwdata,
  input  logic                          pready,
  input  logic                          pslverr,
  input  logic [DATA_WIDTH-1:0]         prdata
);
  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > ARB_MAX_REQ || TIMEOUT < 1) begin : g_bad_cfg
    $error("apb_master_arbiter: unsupported NUM_REQ or TIMEOUT");
  end

  apb_arb_state_e        state;
  logic [IDX_W-1:0]      cur;
  logic [NUM_REQ-1:0]    cur_mask;
  logic [NUM_REQ-1:0]    arb_req;
  logic                  arb_gnt_vld;
  logic [IDX_W-1:0]      arb_gnt_idx;
  logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];
`ifdef APB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT) + 1;
  logic [TW-1:0]         tcnt;
`endif

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Arbitrate from IDLE, or at completion with the finishing requester masked
  // because its req_valid is still high on that edge.
  always_comb begin
    cur_mask      = '0;
    cur_mask[cur] = 1'b1;
    arb_req       = '0;
    if (state == IDLE) arb_req = req_valid;
    else if (state == ACCESS && pready) arb_req = req_valid & ~cur_mask;
  end

  apb_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .pclk    (pclk),
    .presetn (presetn),
    .req     (arb_req),
    .gnt_vld (arb_gnt_vld),
    .gnt_idx (arb_gnt_idx)
  );

  assign busy = psel;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state      <= IDLE;
      cur        <= '0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      req_done   <= '0;
      req_rdata  <= '0;
      req_slverr <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      tcnt       <= '0;
`endif
    end else begin
      req_done <= '0;
      case (state)
        IDLE: begin
          if (arb_gnt_vld) begin
            cur    <= arb_gnt_idx;
            paddr  <= addr_arr[arb_gnt_idx];
            pwrite <= req_write[arb_gnt_idx];
            pwdata <= wdata_arr[arb_gnt_idx];
            psel   <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
          tcnt    <= '0;
`endif
        end
        ACCESS: begin
          if (pready) begin
            req_done[cur] <= 1'b1;
            req_rdata     <= pwrite ? '0 : prdata;
            req_slverr    <= pslverr;
            penable       <= 1'b0;
            if (arb_gnt_vld) begin
              cur    <= arb_gnt_idx;
              paddr  <= addr_arr[arb_gnt_idx];
              pwrite <= req_write[arb_gnt_idx];
              pwdata <= wdata_arr[arb_gnt_idx];
              state  <= SETUP;
            end else begin
              psel  <= 1'b0;
              state <= IDLE;
            end
          end
`ifdef APB_ARB_TIMEOUT_EN
          else if (tcnt == TW'(TIMEOUT - 1)) begin
            req_done[cur] <= 1'b1;
            req_rdata     <= '0;
            req_slverr    <= 1'b1;
            psel          <= 1'b0;
            penable       <= 1'b0;
            state         <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_master_arbiter.sv
// Randomized and directed bench for apb_master_arbiter: a transaction-level
// round-robin model predicts the bus, a per-requester scoreboard checks completions.
module tb_apb_master_arbiter;
  localparam int N = 4, AW = 32, DW = 32, TMO = 4;

  logic            pclk = 1'b0, presetn = 1'b0;
  logic [N-1:0]    req_valid, req_write, req_done;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   req_rdata, pwdata, prdata;
  logic [AW-1:0]   paddr;
  logic            req_slverr, busy, psel, penable, pwrite, pready, pslverr;

  logic          v   [N];
  logic [AW-1:0] a_r [N];
  logic          w_r [N];
  logic [DW-1:0] d_r [N];
  logic [32:0]   exp_q [N][$];
  int            gnt_log[$];
  int            n_cmp = 0, n_bad = 0, lat_d [N];

  apb_master_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .pclk(pclk), .presetn(presetn), .req_valid(req_valid), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata), .req_done(req_done), .req_rdata(req_rdata),
    .req_slverr(req_slverr), .busy(busy), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  always #5 pclk = ~pclk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_valid[i]            = v[i];
      req_write[i]            = w_r[i];
      req_addr[i*AW +: AW]    = a_r[i];
      req_wdata[i*DW +: DW]   = d_r[i];
    end
  end

  function automatic logic [DW-1:0] rd_of(input logic [AW-1:0] a);
    return (a * 32'h9E37) ^ 32'h5A5A_0000;
  endfunction
  function automatic logic err_of(input logic [AW-1:0] a);
    return a[3:0] == 4'hC;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Memory-like slave: read data and error are functions of the address.
  assign prdata  = rd_of(paddr);
  assign pslverr = err_of(paddr);
  int wt = 0, acc_n = 0, fixed_wait = 0;
  bit rand_wait = 1'b0;
  always @(negedge pclk) begin
    if (psel && penable) begin
      pready = (acc_n >= wt);
      acc_n++;
    end else begin
      acc_n  = 0;
      pready = 1'b0;
      wt     = rand_wait ? int'($urandom_range(0, 2)) : fixed_wait;
    end
  end

  // Reference model: bus phase, round-robin pointer and current transfer.
  bit            m_psel = 0, m_pen = 0, comp, tmo, found;
  int            m_ptr = 0, m_cur = 0, m_wait = 0, g;
  logic [AW-1:0] m_addr;
  logic          m_wr;
  logic [DW-1:0] m_wd;
  logic [N-1:0]  exp_done, mask, cand;
  logic [32:0]   e;

  always @(posedge pclk) begin
    #1;
    if (!presetn) begin
      m_psel = 0; m_pen = 0; m_ptr = 0; m_wait = 0;
    end else begin
      comp = 0; tmo = 0; exp_done = '0; mask = '0;
      if (m_psel && m_pen) begin
        if (pready) comp = 1;
`ifdef APB_ARB_TIMEOUT_EN
        else if (m_wait == TMO - 1) tmo = 1;
`endif
        else m_wait++;
      end
      if (comp || tmo) exp_done[m_cur] = 1'b1;
      if (!m_psel || comp) begin
        if (comp) mask[m_cur] = 1'b1;
        cand  = req_valid & ~mask;
        found = 0; g = 0;
        for (int k = 0; k < N; k++)
          if (!found && cand[(m_ptr + k) % N]) begin g = (m_ptr + k) % N; found = 1; end
        if (found) begin
          m_cur = g; m_ptr = (g + 1) % N; m_psel = 1; m_pen = 0; m_wait = 0;
          m_addr = a_r[g]; m_wr = w_r[g]; m_wd = d_r[g];
          gnt_log.push_back(g);
        end else begin
          m_psel = 0; m_pen = 0;
        end
      end else if (tmo) begin
        m_psel = 0; m_pen = 0;
      end else begin
        m_pen = 1;
      end
      chk("psel", psel, m_psel);
      chk("penable", penable, m_pen);
      chk("busy", busy, m_psel);
      chk("req_done", req_done, exp_done);
      if (m_psel) begin
        chk("paddr", paddr, m_addr);
        chk("pwrite", pwrite, m_wr);
        chk("pwdata", pwdata, m_wd);
      end
      for (int i = 0; i < N; i++) begin
        if (req_done[i]) begin
          if (exp_q[i].size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL done_unexpected req%0d: got a req_done, expected none", i);
          end else begin
            e = exp_q[i].pop_front();
            chk($sformatf("rdata_req%0d", i), req_rdata, e[31:0]);
            chk($sformatf("slverr_req%0d", i), req_slverr, e[32]);
          end
        end
      end
    end
  end

  // Issue one transfer at a negedge, hold it until req_done, then drop it.
  task automatic do_req(input int i, input logic [AW-1:0] a, input logic wr,
                        input logic [DW-1:0] d, input bit forced, output int lat);
    if (forced) exp_q[i].push_back({1'b1, 32'h0});
    else exp_q[i].push_back({err_of(a), wr ? 32'h0 : rd_of(a)});
    v[i] = 1'b1; a_r[i] = a; w_r[i] = wr; d_r[i] = d;
    lat = 0;
    while (1'b1) begin
      @(posedge pclk); #1;
      lat++;
      if (req_done[i]) break;
      if (lat > 300) begin
        n_cmp++; n_bad++;
        $display("FAIL done_wait req%0d: got no req_done, expected one within 300 cycles", i);
        break;
      end
    end
    @(negedge pclk);
    v[i] = 1'b0;
  endtask

  task automatic drv(input int i);
    int l;
    for (int t = 0; t < 20; t++) begin
      repeat ($urandom_range(0, 3)) @(negedge pclk);
      do_req(i, $urandom & 32'h3FC, 1'($urandom_range(0, 1)), $urandom, 1'b0, l);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_psel"}, psel, 0);       chk({tag, "_penable"}, penable, 0);
    chk({tag, "_paddr"}, paddr, 0);     chk({tag, "_pwrite"}, pwrite, 0);
    chk({tag, "_pwdata"}, pwdata, 0);   chk({tag, "_req_done"}, req_done, 0);
    chk({tag, "_rdata"}, req_rdata, 0); chk({tag, "_slverr"}, req_slverr, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int lat;
    for (int i = 0; i < N; i++) begin v[i] = 0; a_r[i] = '0; w_r[i] = 0; d_r[i] = '0; end
    repeat (3) @(negedge pclk);
    chk_all_zero("reset");
    presetn = 1'b1;
    @(negedge pclk);

    // All four at once from pointer 0, two transfers each.
    gnt_log.delete();
    fork
      begin do_req(0, 32'h100, 1, 32'h11, 0, lat_d[0]); do_req(0, 32'h104, 0, 0, 0, lat_d[0]); end
      begin do_req(1, 32'h110, 0, 0, 0, lat_d[1]);      do_req(1, 32'h114, 1, 32'h22, 0, lat_d[1]); end
      begin do_req(2, 32'h120, 1, 32'h33, 0, lat_d[2]); do_req(2, 32'h124, 0, 0, 0, lat_d[2]); end
      begin do_req(3, 32'h130, 0, 0, 0, lat_d[3]);      do_req(3, 32'h134, 1, 32'h44, 0, lat_d[3]); end
    join
    chk("gnt_log_size", gnt_log.size() >= 5, 1);
    for (int k = 0; k < 5 && k < gnt_log.size(); k++)
      chk($sformatf("grant_order%0d", k), gnt_log[k], k % N);

    do_req(0, 32'h10, 1, 32'hA5A5_A5A5, 0, lat);
    chk("lat_single_write", lat, 3);

    fixed_wait = 3;
    do_req(2, 32'h20, 0, 0, 0, lat);
    chk("lat_read_wait3", lat, 6);
    fixed_wait = 0;

    do_req(1, 32'h1C, 1, 32'hDEAD_BEEF, 0, lat);
    chk("lat_slverr", lat, 3);
    do_req(1, 32'h30, 0, 0, 0, lat);
    chk("lat_after_err", lat, 3);

    // Requester 1 appears and vanishes while requester 0 owns the bus.
    fixed_wait = 3;
    fork
      do_req(0, 32'h40, 0, 0, 0, lat);
      begin
        @(negedge pclk);
        v[1] = 1; a_r[1] = 32'h50; w_r[1] = 0;
        repeat (2) @(negedge pclk);
        v[1] = 0;
      end
    join
    fixed_wait = 0;

    // Reset during ACCESS; requester 3 is waiting.
    fixed_wait = 1000;
    v[2] = 1; a_r[2] = 32'h60; w_r[2] = 1; d_r[2] = 32'h6666;
    for (int c = 0; c < 10 && !penable; c++) @(negedge pclk);
    chk("reset_test_in_access", penable, 1);
    v[3] = 1; a_r[3] = 32'h70; w_r[3] = 0;
    @(negedge pclk);
    presetn = 1'b0;
    #1;
    chk_all_zero("midreset");
    v[2] = 0; fixed_wait = 0;
    @(negedge pclk);
    presetn = 1'b1;
    gnt_log.delete();
    do_req(3, 32'h70, 0, 0, 0, lat);
    chk("post_reset_grant_valid", gnt_log.size() >= 1, 1);
    if (gnt_log.size() >= 1) chk("post_reset_grant", gnt_log[0], 3);

`ifdef APB_ARB_TIMEOUT_EN
    fixed_wait = 1000;
    do_req(0, 32'h80, 0, 0, 1, lat);
    chk("lat_timeout", lat, 6);
    chk("psel_after_timeout", psel, 0);
    fixed_wait = 0;
    @(negedge pclk);
`endif

    rand_wait = 1'b1;
    fork
      drv(0); drv(1); drv(2); drv(3);
    join
    rand_wait = 1'b0;
    repeat (5) @(negedge pclk);
    for (int i = 0; i < N; i++) chk($sformatf("pending_req%0d", i), exp_q[i].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    n_bad++;
    $display("FAIL watchdog: got no end of test, expected finish before 400000");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Shares a single APB master port among `NUM_REQ` internal requesters. It sits between the requester blocks and the APB fabric: the arbitration side takes simple hold-until-done requests, and the bus side drives `psel`, `penable`, `paddr`, `pwrite` and `pwdata` through the APB SETUP/ACCESS sequence. Arbitration is round-robin. Completion, read data and slave error are returned to the granted requester.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `ADDR_WIDTH`, default `` `ADDR_WIDTH ``: APB address width.
- `DATA_WIDTH`, default `` `DATA_WIDTH ``: APB data width.
- `TIMEOUT`, default 16: maximum ACCESS wait cycles. Only used with `APB_ARB_TIMEOUT_EN`.

Ports:
- `pclk`  in  1  clock; all logic on the rising edge.
- `presetn`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NUM_REQ  per-requester transfer request.
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at slice i.
- `req_write`  in  NUM_REQ  1 = write.
- `req_wdata`  in  NUM_REQ*DATA_WIDTH  packed write data.
- `req_done`  out  NUM_REQ  one-hot, one-cycle completion pulse.
- `req_rdata`  out  DATA_WIDTH  read data; valid with `req_done`.
- `req_slverr`  out  1  error status; valid with `req_done`.
- `busy`  out  1  transfer in progress (SETUP or ACCESS).
- `psel`, `penable`, `pwrite`  out  1  APB control.
- `paddr`  out  ADDR_WIDTH  APB address.
- `pwdata`  out  DATA_WIDTH  APB write data.
- `pready`, `pslverr`  in  1  APB slave response.
- `prdata`  in  DATA_WIDTH  APB read data.

## Operation
- **States:** IDLE, SETUP, ACCESS.
- **IDLE:**
  - If any `req_valid` is high, grant the first requester at or after the round-robin pointer.
  - Latch its addr, write and wdata onto `paddr`, `pwrite` and `pwdata`.
  - Set `psel`=1, go to SETUP.
  - Set the pointer to grant+1, modulo `NUM_REQ`.
- **SETUP:** set `penable`=1, go to ACCESS. Bus fields are held stable.
- **ACCESS with `pready`=0:** stay in ACCESS; all outputs held.
- **ACCESS with `pready`=1 (completion):**
  - Pulse `req_done[grant]` for one cycle.
  - `req_rdata` = `prdata` on reads, 0 on writes.
  - `req_slverr` = `pslverr`.
  - `penable`=0.
  - If another `req_valid` is pending (the completing requester is excluded that cycle), arbitrate immediately: go straight to SETUP with `psel` kept at 1 and new fields.
  - Otherwise `psel`=0, go to IDLE.
- **Requester contract:** hold `req_valid` and fields until `req_done`; drop `req_valid` in the `req_done` cycle.
- **Early drop:** a request dropped before grant is ignored with no `req_done`. A request dropped after grant still completes and still pulses `req_done`.
- **Simultaneous requests:** exactly one grant per arbitration. Fairness: each active requester is served within `NUM_REQ` transfers.
- **Reset (`presetn`=0, any time including mid-transfer):**
  - All outputs go to 0 immediately: `psel`, `penable`, `paddr`, `pwrite`, `pwdata`, `req_done`, `req_rdata`, `req_slverr`, `busy`.
  - State returns to IDLE, pointer to 0, timeout counter to 0.
  - The interrupted transfer is lost and gets no `req_done`.

## Timing
- All outputs are registered.
- `req_valid` first sampled high at edge k (in IDLE) gives SETUP (`psel`=1) after edge k, and ACCESS (`penable`=1) after edge k+1.
- With `pready` high at the first ACCESS edge (k+2), `req_done` is high in the cycle after edge k+2. Minimum latency is 3 cycles.
- Back-to-back transfers cost 2 cycles plus wait states, with no IDLE gap.
- `busy` = `psel`.

## Configuration
- Macro: `APB_ARB_TIMEOUT_EN`.
- **Defined:**
  - A counter of width clog2(`TIMEOUT`)+1 counts ACCESS cycles with `pready`=0.
  - When `TIMEOUT` such cycles have elapsed and `pready` is still 0, force completion: `req_done` pulse, `req_slverr`=1, `req_rdata`=0, `psel`=`penable`=0, go to IDLE.
  - The counter clears on entry to SETUP.
- **Undefined:** no counter; ACCESS waits indefinitely; `TIMEOUT` is ignored.

## Structure
- Package `apb_arb_pkg` holds:
  - `apb_arb_state_e` enum (IDLE, SETUP, ACCESS).
  - Localparam `ARB_MAX_REQ` = 8.
- Sub-module `apb_rr_arbiter`: combinational round-robin grant from the request vector and pointer, plus a registered pointer update on grant.
- The FSM, bus registers and timeout counter live in the top module.

## Test plan
- **Single write.** Req0 write, addr 0x10, wdata 0xA5A5A5A5, `pready` tied 1.
  - `psel`/`penable` pattern over 2 cycles with paddr 0x10 and pwdata 0xA5A5A5A5.
  - `req_done[0]` pulse 3 cycles after request; `req_slverr`=0.
- **Read with wait states.** Req2 read, addr 0x20; `pready` low for 3 ACCESS cycles, then high with `prdata`=0x1234.
  - `req_rdata`=0x1234 with `req_done[2]`; latency 6 cycles.
- **All four requesting.** All 4 request continuously.
  - Grant order 0, 1, 2, 3, 0.
  - `psel` never drops between transfers; exactly one `req_done` bit per completion.
- **Slave error.** `pslverr`=1 with `pready` on a write from req1.
  - `req_done[1]` with `req_slverr`=1; next transfer proceeds normally.
- **Reset mid-transfer.** Assert `presetn` low in ACCESS.
  - All outputs 0 within the same cycle; no `req_done`.
  - After release, the pending req3 is granted first from pointer 0 order (req0 absent).
- **Timeout (with `APB_ARB_TIMEOUT_EN`, `TIMEOUT`=4).** `pready` held 0.
  - Forced `req_done` with `req_slverr`=1 after 4 ACCESS cycles; `psel` returns to 0.
